// File: rtl/hls_fp32_sub_chn_o_rsci_out_ctrl_if.sv
// ---------------------------------------------------------------------------
// hls_fp32_sub_chn_o_rsci_out_ctrl_if
// Downstream valid/ready stream of the fp32 sub core output channel chn_o.
//   chn_o_rsc_lz : valid, driven by the channel (master)
//   chn_o_rsc_vz : ready, driven by downstream NVDLA logic (slave)
//   chn_o_rsc_z  : payload, driven by the channel (master)
// ---------------------------------------------------------------------------
interface hls_fp32_sub_chn_o_rsci_out_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              chn_o_rsc_lz;
    logic              chn_o_rsc_vz;
    logic [DATA_W-1:0] chn_o_rsc_z;

    modport master (
        output chn_o_rsc_lz,
        output chn_o_rsc_z,
        input  chn_o_rsc_vz
    );

    modport slave (
        input  chn_o_rsc_lz,
        input  chn_o_rsc_z,
        output chn_o_rsc_vz
    );
endinterface

// File: rtl/hls_fp32_sub_chn_o_rsci_out_ctrl.sv
// ---------------------------------------------------------------------------
// hls_fp32_sub_chn_o_rsci_out_ctrl
// Transmit-side channel for the fp32 sub core output chn_o. Core write
// requests (core_wen/core_wten stall discipline) are turned into a
// valid/ready stream through a 2-entry buffer (head + skid). Downstream
// ready never reaches a core-side output combinationally: acceptance only
// depends on the registered occupancy.
//
// Ports:
//   nvdla_core_clk, nvdla_core_rstn : clock, async active-low reset
//   chn_o_rsci_oswt                 : core requests an output write this state
//   core_wen, core_wten             : core enable / registered stall indication
//   chn_o_rsci_iswt0                : core issues a write this cycle
//   chn_o_rsci_ld_core_psct         : core pseudo-select for the write
//   chn_o_rsci_d                    : result data from the core
//   chn_o_rsci_biwt                 : write accepted into the buffer this cycle
//   chn_o_rsci_bdwt                 : oswt & core_wen
//   chn_o_rsci_ld_core_sct          : ld_core_psct & ogwt
//   chn_o_rsci_wen_comp             : channel does not stall the core
//   chn_o_rsc (master)              : downstream lz/vz/z stream
//
// Optional feature (macro HLS_FP32_SUB_CHN_O_STALL_CNT_EN):
//   chn_o_stall_clr  : synchronous clear of the stall counter
//   chn_o_stall_cnt  : saturating count of cycles with lz & ~vz
// ---------------------------------------------------------------------------
module hls_fp32_sub_chn_o_rsci_out_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              chn_o_rsci_oswt,
    input  logic              core_wen,
    input  logic              core_wten,
    input  logic              chn_o_rsci_iswt0,
    input  logic              chn_o_rsci_ld_core_psct,
    input  logic [DATA_W-1:0] chn_o_rsci_d,
    output logic              chn_o_rsci_biwt,
    output logic              chn_o_rsci_bdwt,
    output logic              chn_o_rsci_ld_core_sct,
    output logic              chn_o_rsci_wen_comp,
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
    input  logic              chn_o_stall_clr,
    output logic [15:0]       chn_o_stall_cnt,
`endif
    hls_fp32_sub_chn_o_rsci_out_ctrl_if.master chn_o_rsc
);

    // Buffer occupancy; the state also encodes head/skid validity
    // (head valid when not EMPTY, skid valid only when FULL).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [DATA_W-1:0] head_data_r;
    logic [DATA_W-1:0] head_data_s;
    logic [DATA_W-1:0] skid_data_r;
    logic [DATA_W-1:0] skid_data_s;
    logic              icwt_r;
    logic              icwt_s;

    logic              pdswt0_s;
    logic              ogwt_s;
    logic              full_s;
    logic              biwt_s;
    logic              lz_s;
    logic              pop_s;

    // Wait-control decode and handshake outputs.
    always_comb begin
        pdswt0_s = chn_o_rsci_iswt0 & ~core_wten;
        ogwt_s   = pdswt0_s | icwt_r;
        full_s   = (state_r == ST_FULL);
        biwt_s   = ogwt_s & ~full_s;
        lz_s     = (state_r != ST_EMPTY);
        pop_s    = lz_s & chn_o_rsc.chn_o_rsc_vz;
    end

    assign chn_o_rsci_biwt        = biwt_s;
    assign chn_o_rsci_bdwt        = chn_o_rsci_oswt & core_wen;
    assign chn_o_rsci_ld_core_sct = chn_o_rsci_ld_core_psct & ogwt_s;
    assign chn_o_rsci_wen_comp    = ~ogwt_s | biwt_s;
    assign chn_o_rsc.chn_o_rsc_lz = lz_s;
    assign chn_o_rsc.chn_o_rsc_z  = head_data_r;

    // Next-state of the buffer: push on biwt, pop on lz & vz.
    always_comb begin
        state_s     = state_r;
        head_data_s = head_data_r;
        skid_data_s = skid_data_r;
        // A request blocked by a full buffer stays pending until accepted.
        icwt_s      = ogwt_s & ~biwt_s;
        case (state_r)
            ST_EMPTY: begin
                if (biwt_s) begin
                    head_data_s = chn_o_rsci_d;
                    state_s     = ST_ONE;
                end else begin
                    state_s     = ST_EMPTY;
                end
            end
            ST_ONE: begin
                case ({biwt_s, pop_s})
                    2'b10: begin
                        skid_data_s = chn_o_rsci_d;
                        state_s     = ST_FULL;
                    end
                    2'b01: begin
                        state_s     = ST_EMPTY;
                    end
                    2'b11: begin
                        // Head drains and refills in the same cycle.
                        head_data_s = chn_o_rsci_d;
                        state_s     = ST_ONE;
                    end
                    default: begin
                        state_s     = ST_ONE;
                    end
                endcase
            end
            ST_FULL: begin
                // No push here: full is taken from the registered state.
                if (pop_s) begin
                    head_data_s = skid_data_r;
                    state_s     = ST_ONE;
                end else begin
                    state_s     = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Buffer and pending-request registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r     <= ST_EMPTY;
            head_data_r <= {DATA_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            icwt_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            head_data_r <= head_data_s;
            skid_data_r <= skid_data_s;
            icwt_r      <= icwt_s;
        end
    end

`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] stall_cnt_s;

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        stall_cnt_s = stall_cnt_r;
        if (chn_o_stall_clr) begin
            stall_cnt_s = 16'h0000;
        end else if (lz_s && !chn_o_rsc.chn_o_rsc_vz && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_s = stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // Stall counter register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt_r <= 16'h0000;
        end else begin
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign chn_o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hls_fp32_sub_chn_o_rsci_out_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hls_fp32_sub_chn_o_rsci_out_ctrl
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the channel.
// Define HLS_FP32_SUB_CHN_O_STALL_CNT_EN to also exercise the stall counter.
// ---------------------------------------------------------------------------
module tb_hls_fp32_sub_chn_o_rsci_out_ctrl;

    logic        clk;
    logic        rst_n;
    logic        oswt;
    logic        wen;
    logic        wten;
    logic        iswt0;
    logic        psct;
    logic [31:0] d;
    logic        biwt;
    logic        bdwt;
    logic        sct;
    logic        wen_comp;
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
    logic        stall_clr;
    logic [15:0] stall_cnt;
    logic [15:0] m_stall;
`endif

    int n_checks;
    int n_errors;

    // Reference model: FIFO contents and the pending-request flag.
    logic [31:0] m_q[$];
    logic        m_pend;

    hls_fp32_sub_chn_o_rsci_out_ctrl_if #(.DATA_W(32)) chn_o_rsc ();

    hls_fp32_sub_chn_o_rsci_out_ctrl #(.DATA_W(32)) dut (
        .nvdla_core_clk          (clk),
        .nvdla_core_rstn         (rst_n),
        .chn_o_rsci_oswt         (oswt),
        .core_wen                (wen),
        .core_wten               (wten),
        .chn_o_rsci_iswt0        (iswt0),
        .chn_o_rsci_ld_core_psct (psct),
        .chn_o_rsci_d            (d),
        .chn_o_rsci_biwt         (biwt),
        .chn_o_rsci_bdwt         (bdwt),
        .chn_o_rsci_ld_core_sct  (sct),
        .chn_o_rsci_wen_comp     (wen_comp),
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
        .chn_o_stall_clr         (stall_clr),
        .chn_o_stall_cnt         (stall_cnt),
`endif
        .chn_o_rsc               (chn_o_rsc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check 1ns later, advance the model at posedge.
    task automatic cycle(input logic i_oswt, input logic i_wen, input logic i_wten,
                         input logic i_isw, input logic i_psct, input logic [31:0] i_d,
                         input logic i_vz, input logic i_clr);
        logic e_lz, e_full, e_og, e_bi;
        @(negedge clk);
        oswt  = i_oswt;
        wen   = i_wen;
        wten  = i_wten;
        iswt0 = i_isw;
        psct  = i_psct;
        d     = i_d;
        chn_o_rsc.chn_o_rsc_vz = i_vz;
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
        stall_clr = i_clr;
`endif
        #1;
        e_lz   = (m_q.size() != 0);
        e_full = (m_q.size() == 2);
        e_og   = (i_isw && !i_wten) || m_pend;
        e_bi   = e_og && !e_full;
        check_val("lz", {31'd0, chn_o_rsc.chn_o_rsc_lz}, {31'd0, e_lz});
        if (e_lz) check_val("z", chn_o_rsc.chn_o_rsc_z, m_q[0]);
        check_val("biwt", {31'd0, biwt}, {31'd0, e_bi});
        check_val("bdwt", {31'd0, bdwt}, {31'd0, i_oswt & i_wen});
        check_val("ld_core_sct", {31'd0, sct}, {31'd0, i_psct & e_og});
        check_val("wen_comp", {31'd0, wen_comp}, {31'd0, !e_og || e_bi});
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
        check_val("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
`endif
        @(posedge clk);
        if (e_lz && i_vz) m_q.delete(0);
        if (e_bi) m_q.push_back(i_d);
        m_pend = e_og && !e_bi;
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
        if (i_clr) m_stall = 16'h0000;
        else if (e_lz && !i_vz && m_stall != 16'hFFFF) m_stall = m_stall + 16'h0001;
`endif
    endtask

    // Shorthand: write request with core running, no stall counter clear.
    task automatic push(input logic i_isw, input logic [31:0] i_d, input logic i_vz);
        cycle(1'b1, 1'b1, 1'b0, i_isw, 1'b1, i_d, i_vz, 1'b0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = 1'b0;
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
        m_stall = 16'h0000;
`endif
    endtask

    initial begin
        logic [31:0] held;
        logic        r_oswt, r_wen, r_wten, r_isw, r_psct, r_vz;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        oswt = 1'b0; wen = 1'b0; wten = 1'b0; iswt0 = 1'b0; psct = 1'b0; d = 32'd0;
        chn_o_rsc.chn_o_rsc_vz = 1'b0;
`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
        stall_clr = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_lz", {31'd0, chn_o_rsc.chn_o_rsc_lz}, 32'd0);
        check_val("rst_z", chn_o_rsc.chn_o_rsc_z, 32'd0);
        check_val("rst_biwt", {31'd0, biwt}, 32'd0);
        check_val("rst_wen_comp", {31'd0, wen_comp}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        // Idle after release: also proves icwt came out of reset clear.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        check_val("idle_z", chn_o_rsc.chn_o_rsc_z, 32'd0);

        // Streaming with ready held high: 1 transfer per cycle.
        for (int i = 1; i <= 4; i++) push(1'b1, i, 1'b1);
        push(1'b0, 32'd0, 1'b1);
        push(1'b0, 32'd0, 1'b1);

        // Backpressure: A, B fill the buffer, C waits pending.
        push(1'b1, 32'hA, 1'b0);
        push(1'b1, 32'hB, 1'b0);
        push(1'b1, 32'hC, 1'b0);
        push(1'b0, 32'hC, 1'b0);
        push(1'b0, 32'hC, 1'b1);
        push(1'b0, 32'hC, 1'b1);
        push(1'b0, 32'hC, 1'b0);
        push(1'b0, 32'd0, 1'b1);
        push(1'b0, 32'd0, 1'b1);

        // Count 1 with simultaneous push and pop.
        push(1'b1, 32'h4, 1'b0);
        push(1'b1, 32'h5, 1'b1);
        push(1'b0, 32'h0, 1'b0);
        push(1'b0, 32'h0, 1'b1);

        // Write blocked by core_wten; bdwt from oswt & core_wen.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h77, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h78, 1'b1, 1'b0);

        // Reset with a full buffer and a pending request.
        push(1'b1, 32'h11, 1'b0);
        push(1'b1, 32'h22, 1'b0);
        push(1'b1, 32'h33, 1'b0);
        @(negedge clk);
        iswt0 = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_lz", {31'd0, chn_o_rsc.chn_o_rsc_lz}, 32'd0);
        check_val("mid_rst_wen_comp", {31'd0, wen_comp}, 32'd1);
        check_val("mid_rst_sct", {31'd0, sct}, 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0);

        // Random traffic; d is held while a request is pending.
        held = 32'd0;
        for (int i = 0; i < 600; i++) begin
            r_oswt = 1'($urandom_range(0, 1));
            r_wen  = 1'($urandom_range(0, 1));
            r_wten = ($urandom_range(0, 3) == 0);
            r_isw  = 1'($urandom_range(0, 1));
            r_psct = 1'($urandom_range(0, 1));
            r_vz   = ($urandom_range(0, 2) != 0);
            if (!m_pend) held = $urandom();
            cycle(r_oswt, r_wen, r_wten, r_isw, r_psct, held, r_vz, 1'b0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, held, 1'b1, 1'b0);

`ifdef HLS_FP32_SUB_CHN_O_STALL_CNT_EN
        // Long stall: counter saturates, then clears with priority.
        push(1'b1, 32'h99, 1'b0);
        for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("stall_clr", {16'd0, stall_cnt}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
